// File: rtl/scan_digit_ctrl_if.sv
// Display-word handshake plus multiplexed digit-drive outputs of scan_digit_ctrl.
// master = word source / display hardware side, slave = the scan controller.
interface scan_digit_ctrl_if;
  logic        i_run;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_ready;
  logic [2:0]  o_sel;
  logic        o_en;
  logic [3:0]  o_nibble;
  logic        o_frame;

  modport master (
    output i_run, i_valid, i_data,
    input  o_ready, o_sel, o_en, o_nibble, o_frame
  );

  modport slave (
    input  i_run, i_valid, i_data,
    output o_ready, o_sel, o_en, o_nibble, o_frame
  );
endinterface

// File: rtl/scan_digit_ctrl.sv
// Eight-digit multiplexed display scanner with a shadow/active word pair; optional LEADING_ZERO_BLANK_EN.
// Latency: o_sel/o_en/o_frame registered, o_nibble combinational from registered sel/active.
// Backpressure: o_ready low while the shadow holds a word; it empties at the next frame wrap (or at once in IDLE).
module scan_digit_ctrl #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned GUARD    = 2
) (
  input  logic             clk,
  input  logic             rst,
  scan_digit_ctrl_if.slave bus
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          frame_q, frame_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          full_q, full_d;
  logic [31:0]   active_q, active_d;
  logic          tick;
  logic          accept;

  assign tick   = (state_q == SCAN) && (cnt_q == LAST);
  assign accept = bus.i_valid && !full_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    frame_d  = 1'b0;
    shadow_d = shadow_q;
    full_d   = full_q;
    active_d = active_q;
    en_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = 3'd0;
        if (full_q) begin
          active_d = shadow_q;
          full_d   = 1'b0;
        end
        if (bus.i_run) state_d = SCAN;
      end
      SCAN: begin
        // Dropping run aborts the slot outright: no frame pulse, no transfer.
        if (!bus.i_run) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 3'd0;
        end else if (tick) begin
          cnt_d = '0;
          sel_d = sel_q + 3'd1;
          if (sel_q == 3'd7) begin
            frame_d = 1'b1;
            if (full_q) begin
              active_d = shadow_q;
              full_d   = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only an empty shadow accepts, so this never collides with a transfer.
    if (accept) begin
      shadow_d = bus.i_data;
      full_d   = 1'b1;
    end

    en_d = (state_d == SCAN) && (cnt_d >= GUARD_C);
`ifdef LEADING_ZERO_BLANK_EN
    if ((sel_d != 3'd0) && ((active_d >> {sel_d, 2'b00}) == 32'd0)) en_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 3'd0;
      en_q     <= 1'b0;
      frame_q  <= 1'b0;
      shadow_q <= 32'd0;
      full_q   <= 1'b0;
      active_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      active_q <= active_d;
    end
  end

  assign bus.o_ready  = !full_q;
  assign bus.o_sel    = sel_q;
  assign bus.o_en     = en_q;
  assign bus.o_frame  = frame_q;
  assign bus.o_nibble = active_q[{sel_q, 2'b00} +: 4];

endmodule

// File: tb/tb_scan_digit_ctrl.sv
// Directed bench for scan_digit_ctrl at PRESCALE=4, GUARD=1; expectations follow LEADING_ZERO_BLANK_EN.
module tb_scan_digit_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   p      = -1;
  logic [31:0] exp_act = 32'd0;

  scan_digit_ctrl_if bus ();

  scan_digit_ctrl #(.PRESCALE(4), .GUARD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s p=%0d got=%0h exp=%0h", tag, p, got, exp);
    end
  endtask

  function automatic logic exp_en(input int cnt, input int sel);
    logic e;
    e = (cnt != 0);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel != 0 && (exp_act >> (4 * sel)) == 32'd0) e = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // One scanning cycle: p counts edges since SCAN was entered.
  task automatic step_scan();
    int cnt, sel;
    tick1();
    p++;
    if (p == 64)  exp_act = 32'h8765_4321;
    if (p == 128) exp_act = 32'h0000_0120;
    cnt = p % 4;
    sel = (p / 4) % 8;
    chk("sel",   {29'd0, bus.o_sel}, sel);
    chk("en",    {31'd0, bus.o_en}, {31'd0, exp_en(cnt, sel)});
    chk("frame", {31'd0, bus.o_frame}, {31'd0, (p > 0) && (p % 32 == 0)});
  endtask

  task automatic run_to(input int target);
    while (p < target) step_scan();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_run   = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hDEAD_BEEF;
    tick1();
    tick1();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    chk("rst_sel",    {29'd0, bus.o_sel}, 0);
    chk("rst_en",     {31'd0, bus.o_en}, 0);
    chk("rst_frame",  {31'd0, bus.o_frame}, 0);
    chk("rst_ready",  {31'd0, bus.o_ready}, 1);
    chk("rst_nibble", {28'd0, bus.o_nibble}, 0);

    bus.i_run = 1'b1;
    run_to(40);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h8765_4321;
    step_scan();
    chk("acc_ready",  {31'd0, bus.o_ready}, 0);
    chk("acc_nib",    {28'd0, bus.o_nibble}, 0);
    bus.i_data  = 32'hAAAA_AAAA;
    step_scan();
    bus.i_valid = 1'b0;
    chk("full_ready", {31'd0, bus.o_ready}, 0);
    run_to(48);
    chk("hold_nib",   {28'd0, bus.o_nibble}, 0);
    run_to(63);
    chk("prewrap_rdy", {31'd0, bus.o_ready}, 0);
    step_scan();
    chk("wrap_ready", {31'd0, bus.o_ready}, 1);
    chk("wrap_nib0",  {28'd0, bus.o_nibble}, 1);
    run_to(92);
    chk("nib7",       {28'd0, bus.o_nibble}, 8);

    run_to(95);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h0000_0120;
    step_scan();
    bus.i_valid = 1'b0;
    chk("tickacc_rdy", {31'd0, bus.o_ready}, 0);
    chk("tickacc_nib", {28'd0, bus.o_nibble}, 1);
    run_to(127);
    chk("old_nib7",   {28'd0, bus.o_nibble}, 8);
    step_scan();
    chk("new_nib0",   {28'd0, bus.o_nibble}, 0);
    chk("new_ready",  {31'd0, bus.o_ready}, 1);
    run_to(132);
    chk("new_nib1",   {28'd0, bus.o_nibble}, 2);
    run_to(136);
    chk("new_nib2",   {28'd0, bus.o_nibble}, 1);

    run_to(145);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h5555_5555;
    step_scan();
    bus.i_valid = 1'b0;
    chk("s5_ready",   {31'd0, bus.o_ready}, 0);
    run_to(149);
    bus.i_run = 1'b0;
    tick1();
    chk("stop_sel",   {29'd0, bus.o_sel}, 0);
    chk("stop_en",    {31'd0, bus.o_en}, 0);
    chk("stop_frame", {31'd0, bus.o_frame}, 0);
    chk("stop_ready", {31'd0, bus.o_ready}, 0);
    tick1();
    chk("idle_xfer_rdy", {31'd0, bus.o_ready}, 1);
    chk("idle_xfer_nib", {28'd0, bus.o_nibble}, 5);
    chk("idle_en",    {31'd0, bus.o_en}, 0);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h9999_9999;
    tick1();
    chk("idle_acc_rdy", {31'd0, bus.o_ready}, 0);

    rst = 1'b1;
    bus.i_run   = 1'b1;
    bus.i_data  = 32'h1234_5678;
    tick1();
    chk("mrst_sel",   {29'd0, bus.o_sel}, 0);
    chk("mrst_en",    {31'd0, bus.o_en}, 0);
    chk("mrst_frame", {31'd0, bus.o_frame}, 0);
    chk("mrst_ready", {31'd0, bus.o_ready}, 1);
    chk("mrst_nib",   {28'd0, bus.o_nibble}, 0);
    rst = 1'b0;
    bus.i_run   = 1'b0;
    bus.i_valid = 1'b0;
    tick1();
    chk("post_ready", {31'd0, bus.o_ready}, 1);
    chk("post_nib",   {28'd0, bus.o_nibble}, 0);
    chk("post_en",    {31'd0, bus.o_en}, 0);
    chk("post_sel",   {29'd0, bus.o_sel}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
